// File: rtl/sio_pkg.sv
// Shared constants and types for the serial-IO command path.
// Latency: n/a (package only).
// Backpressure: n/a.
package sio_pkg;

   // Default link frame period in clocks.
   localparam int          FRAME_LEN_DEF = 128;

   // Data word returned to a requester whose read never came back.
   localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

   // Requester index width inside a tag; covers up to 8 requesters.
   localparam int          TAG_IDX_W     = 3;

   // Target register address map.
   typedef enum logic [3:0] {
      ADDR_RESET = 4'd0,
      ADDR_SYNC  = 4'd1,
      ADDR_SPI0  = 4'd2,
      ADDR_SPI1  = 4'd3,
      ADDR_ID    = 4'd4
   } sio_addr_e;

   // Response-routing tag: which requester owns the command slot.
   typedef struct packed {
      logic                 vld;
      logic [TAG_IDX_W-1:0] idx;
   } sio_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts at the index after the last grant.
// Latency: grant is combinational; the pointer advances on the edge of an enabled grant.
// Backpressure: none; nothing is granted while i_en is low, and the pointer then holds.
// Ports: i_clock, i_reset (sync, active-high), i_req[N] requests, i_en grant enable,
//        o_gnt[N] one-hot grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic [N-1:0] i_req,
   input  logic         i_en,
   output logic [N-1:0] o_gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_sel;
   logic          w_hit;
   int            w_cand;

   // Walk the candidates in priority order (r_ptr, r_ptr+1, ...) and take the
   // first one requesting. The inner loop keeps every vector select constant.
   always_comb begin
      w_hit  = 1'b0;
      w_sel  = '0;
      w_cand = 0;
      o_gnt  = '0;
      for (int k = 0; k < N; k++) begin
         w_cand = int'(r_ptr) + k;
         if (w_cand >= N) begin
            w_cand = w_cand - N;
         end
         for (int j = 0; j < N; j++) begin
            if (!w_hit && (w_cand == j) && i_req[j]) begin
               w_hit    = 1'b1;
               w_sel    = PW'(j);
               o_gnt[j] = i_en;
            end
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_ptr <= '0;
      end else if (i_en && w_hit) begin
         r_ptr <= (w_sel == PW'(N - 1)) ? '0 : w_sel + PW'(1);
      end
   end

endmodule

// File: rtl/sio_cmd_arbiter.sv
// Framed command-slot arbiter: one requester per frame wins the link slot; its read word is routed back by tag.
// Latency: grant at frame cycle FRAME_LEN-1, command shown the next frame, response LAT_FRAMES frames later plus one clock.
// Backpressure: requesters hold req_valid until the req_ready pulse; responses are unconditional pulses.
// Ports: clock, reset (sync, active-high); req_valid/req_ready/req_addr/req_wdata per-requester command;
//        frame_start, cmd_valid/cmd_addr/cmd_wdata command slot; link_rvalid/link_rdata returned word;
//        rsp_valid (one-hot), rsp_rdata, rsp_err response.
module sio_cmd_arbiter
   import sio_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int FRAME_LEN  = FRAME_LEN_DEF,
   parameter int LAT_FRAMES = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [4*N_REQ-1:0]    req_addr,
   input  logic [16*N_REQ-1:0]   req_wdata,
   output logic                  frame_start,
   output logic                  cmd_valid,
   output logic [3:0]            cmd_addr,
   output logic [15:0]           cmd_wdata,
   input  logic                  link_rvalid,
   input  logic [15:0]           link_rdata,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [15:0]           rsp_rdata,
   output logic                  rsp_err
);

   localparam int CW = $clog2(FRAME_LEN);

   logic [CW-1:0]        r_cnt;
   logic                 w_last;
   logic                 w_arb_en;
   logic [N_REQ-1:0]     w_gnt;
   logic [TAG_IDX_W-1:0] w_gidx;
   logic [3:0]           w_addr;
   logic [15:0]          w_wdata;

   // r_tag[0] is the newest slot owner; r_own is the owner whose response is due this frame.
   sio_tag_t             r_tag [LAT_FRAMES];
   sio_tag_t             r_own;

   logic                 r_cmd_vld;
   logic [3:0]           r_cmd_addr;
   logic [15:0]          r_cmd_wdata;
   logic [N_REQ-1:0]     r_rsp_vld;
   logic [15:0]          r_rsp_rdata;
   logic                 r_rsp_err;

   assign w_last   = (r_cnt == CW'(FRAME_LEN - 1));
   assign w_arb_en = w_last && !reset;

   // The counter is parked at 0 during reset; masking with reset makes the
   // first frame_start land on the first cycle after release.
   assign frame_start = (r_cnt == '0) && !reset;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .i_clock (clock),
      .i_reset (reset),
      .i_req   (req_valid),
      .i_en    (w_arb_en),
      .o_gnt   (w_gnt)
   );

   assign req_ready = w_gnt;

   // Select the winner's command; all zeros when nobody is granted so an idle slot reads back as 0.
   always_comb begin
      w_gidx  = '0;
      w_addr  = '0;
      w_wdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_gidx  = TAG_IDX_W'(i);
            w_addr  = req_addr[4*i +: 4];
            w_wdata = req_wdata[16*i +: 16];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= '0;
         r_own       <= '0;
         r_cmd_vld   <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_rsp_vld   <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         for (int i = 0; i < LAT_FRAMES; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_cnt     <= w_last ? '0 : r_cnt + CW'(1);
         r_rsp_vld <= '0;

         // A returned word beats the timeout, including on the last frame cycle.
         if (link_rvalid && r_own.vld) begin
            for (int i = 0; i < N_REQ; i++) begin
               r_rsp_vld[i] <= (r_own.idx == TAG_IDX_W'(i));
            end
            r_rsp_rdata <= link_rdata;
            r_rsp_err   <= 1'b0;
            r_own.vld   <= 1'b0;
         end else if (w_last && r_own.vld) begin
            for (int i = 0; i < N_REQ; i++) begin
               r_rsp_vld[i] <= (r_own.idx == TAG_IDX_W'(i));
            end
            r_rsp_rdata <= TIMEOUT_RDATA;
            r_rsp_err   <= 1'b1;
         end

         // Frame boundary: latch the new command, advance the tag pipeline.
         // The r_own load here overrides the consume above for the outgoing owner.
         if (w_last) begin
            r_cmd_vld   <= |w_gnt;
            r_cmd_addr  <= w_addr;
            r_cmd_wdata <= w_wdata;
            r_own       <= r_tag[LAT_FRAMES-1];
            for (int i = LAT_FRAMES - 1; i > 0; i--) begin
               r_tag[i] <= r_tag[i-1];
            end
            r_tag[0].vld <= |w_gnt;
            r_tag[0].idx <= w_gidx;
         end
      end
   end

   assign cmd_valid = r_cmd_vld;
   assign cmd_addr  = r_cmd_addr;
   assign cmd_wdata = r_cmd_wdata;
   assign rsp_valid = r_rsp_vld;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: doc/sio_cmd_arbiter.md
SIO_CMD_ARBITER -- requirements
Module: sio_cmd_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter FRAME_LEN, default 128: link frame period in clocks.
REQ-003 SHALL have parameter LAT_FRAMES, default 1: frames from command slot to response (1..3).
REQ-004 SHALL have ports, in this order:
 clock  in  1  system clock, 31.25 MHz; the block uses one clock.
 reset  in  1  reset, synchronous and active-high.
 req_valid  in  N_REQ  per-requester command pending.
 req_ready  out  N_REQ  per-requester command accepted (1-cycle pulse).
 req_addr  in  4*N_REQ  per-requester register address, requester i at [4i+3:4i].
 req_wdata  in  16*N_REQ  per-requester write data, requester i at [16i+15:16i].
 frame_start  out  1  1-cycle pulse at frame cycle 0.
 cmd_valid  out  1  command slot occupied this frame.
 cmd_addr  out  4  slot address.
 cmd_wdata  out  16  slot data.
 link_rvalid  in  1  read word received from target (pulse).
 link_rdata  in  16  received read word.
 rsp_valid  out  N_REQ  one-hot response pulse to the owning requester.
 rsp_rdata  out  16  response data.
 rsp_err  out  1  response is a timeout (qualified by rsp_valid).

Function
REQ-005 SHALL run a frame counter 0..FRAME_LEN-1 that wraps to 0; frame_start SHALL be high exactly when the counter is 0.
REQ-006 At counter FRAME_LEN-1, SHALL grant one requester with req_valid high, chosen round-robin starting from the index after the last granted requester; after reset the search starts at index 0.
REQ-007 The grant SHALL pulse req_ready[i] for that cycle only; the addr and wdata of requester i SHALL be latched on the same edge.
REQ-008 A requester SHALL hold req_valid, req_addr and req_wdata stable until req_ready; deasserting req_valid earlier withdraws the request without error.
REQ-009 From the frame_start cycle, cmd_valid, cmd_addr and cmd_wdata SHALL present the latched command for the whole frame.
REQ-010 If no requester is valid at FRAME_LEN-1, the next frame SHALL be idle: cmd_valid=0, cmd_addr=0, cmd_wdata=0, and the round-robin pointer unchanged.
REQ-011 SHALL keep a tag pipeline LAT_FRAMES deep that shifts at frame_start; each entry is {valid, requester index}; idle frames insert valid=0.
REQ-012 The response owner for the current frame SHALL be the tag entry that entered LAT_FRAMES frames earlier.
REQ-013 On the first link_rvalid in a frame with a valid owner tag, SHALL assert rsp_valid[owner] one cycle later with rsp_rdata=link_rdata and rsp_err=0, then mark the tag consumed.
REQ-014 SHALL ignore link_rvalid when the owner tag is invalid or already consumed.
REQ-015 If the frame reaches FRAME_LEN-1 with an unconsumed valid owner tag, SHALL assert rsp_valid[owner] on the next cycle (counter 0) with rsp_err=1 and rsp_rdata=16'hDEAD.
REQ-016 link_rvalid at counter FRAME_LEN-1 SHALL take priority over the timeout for the same tag.
REQ-017 rsp_valid SHALL be at most one-hot and one cycle wide; rsp_rdata and rsp_err SHALL hold their last values when rsp_valid is low.

Reset
REQ-018 While reset is high: frame counter=0, round-robin pointer=0, tag pipeline all invalid, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, cmd_valid=0, cmd_addr=0, cmd_wdata=0, frame_start=0.
REQ-019 After reset deasserts, the first frame_start SHALL occur on the first cycle after release. Outstanding requests and responses SHALL be discarded without any rsp_valid.

Structure
REQ-020 FRAME_LEN default, the timeout data word 16'hDEAD and the address map constants (RESET=0, SYNC=1, SPI0=2, SPI1=3, ID=4) SHALL live in shared package sio_pkg.
REQ-021 The round-robin grant SHALL be one sub-module, rr_arbiter (N-bit request, enable, one-hot grant, internal pointer); everything else stays in sio_cmd_arbiter.

Verification
REQ-022 Reset release, no requests -> frame_start every 128 clocks, cmd_valid stays 0 and no rsp_valid for 4 frames.
REQ-023 Requester 2 has addr=4 and wdata=0; link_rvalid with link_rdata=16'hCAFE in the next frame -> req_ready[2] at cycle 127, then rsp_valid=4'b0100 with rsp_rdata=16'hCAFE and rsp_err=0.
REQ-024 All four requesters valid continuously -> grants in order 0,1,2,3,0 on consecutive frames; each requester receives exactly one response per grant.
REQ-025 Command issued and no link_rvalid in the response frame -> rsp_valid to the owner at counter 0 with rsp_err=1 and rsp_rdata=16'hDEAD.
REQ-026 link_rvalid during an idle-owner frame, plus a second link_rvalid in a valid frame -> no rsp_valid for the first pulse, exactly one rsp_valid for the second.
REQ-027 Reset asserted at counter 60 with a command outstanding -> all outputs return to reset values, no late rsp_valid, and the round-robin restarts at requester 0.
